muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that owns the HI/LO architectural registers.
- Replaces the single-cycle HI/LO path in the execute stage.
- Handles MULT/MULTU/DIV/DIVU/MADD/MSUB over WIDTH+1 busy cycles, plus single-cycle MTHI/MTLO.
- Busy feeds the hazard unit, which stalls MFHI/MFLO and any new HI/LO op until Done.

Parameters:
- WIDTH, 32: operand and HI/LO width; must be at least 4.
- ENABLE_MADD, 1: when 0, ops MADD/MSUB are no-ops and never start.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  op request; sampled only in IDLE.
- Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- OperandA  input  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source).
- OperandB  input  WIDTH  rt value (multiplier / divisor).
- Cancel  input  1  flush from branch/jump; aborts the in-flight op.
- Busy  output  1  high while an iterative op is in flight.
- Done  output  1  one-cycle pulse; HI/LO already hold the new result in that cycle.
- DivByZero  output  1  pulses with Done when a DIV/DIVU had OperandB==0.
- HI  output  WIDTH  HI register (registered).
- LO  output  WIDTH  LO register (registered).

Behaviour:
- Reset, asynchronous: state=IDLE; HI=LO=0; Busy=Done=DivByZero=0; all datapath registers cleared.
- States: IDLE -> CALC (WIDTH cycles, iteration counter WIDTH-1 down to 0) -> FIX (1 cycle) -> IDLE.
- Busy = (state != IDLE), decoded from registered state.
- Timing: Start sampled high at end of cycle 0 -> Busy high cycles 1..WIDTH+1 -> HI/LO written at end of cycle WIDTH+1 -> Done (and DivByZero if applicable) high in cycle WIDTH+2, Busy low. The unit accepts a new Start in cycle WIDTH+2.
- Operands are latched at Start; later changes on OperandA/OperandB have no effect.
- MTHI/MTLO: write HI or LO at the Start edge, state stays IDLE, no Busy, no Done.
- Start while Busy: ignored entirely, including MTHI/MTLO.
- Multiply:
  - Radix-2 shift-add, one bit per CALC cycle, on magnitudes into a 2*WIDTH product.
  - Signed ops (MULT, MADD, MSUB) take |A|, |B| and negate the product in FIX if the signs differ.
  - MADD: {HI,LO} += product mod 2^(2*WIDTH), computed in FIX. MSUB: {HI,LO} -= product.
  - The HI/LO value used by MADD/MSUB is the value held at the FIX cycle.
- Divide:
  - Restoring, one quotient bit per CALC cycle, on magnitudes.
  - Signed: quotient truncates toward zero and is negated when the signs differ; remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - MIN/-1 (signed): LO=MIN, HI=0, no flag.
  - OperandB==0: full latency still runs; LO=all ones, HI=OperandA (raw); DivByZero pulses with Done. Applies to DIV and DIVU.
- Cancel:
  - In CALC or FIX: return to IDLE at that edge; HI/LO unchanged; no Done.
  - Cancel with Start in IDLE: Cancel wins; nothing starts, MTHI/MTLO included.
  - Cancel in the Done cycle: no effect; the result is already committed.
- Reset mid-operation: immediate return to IDLE with HI=LO=0; no Done.
- ENABLE_MADD=0: Start with Op 4/5 is treated like Cancel-in-IDLE; no state change.

Decomposition:
- Package muldiv_pkg holds:
  - op code localparams (OP_MULT..OP_MTLO);
  - state encoding (ST_IDLE, ST_CALC, ST_FIX);
  - counter width function clog2(WIDTH).
- No sub-module required; sign conditioning (abs/negate) is an inline function in muldiv_pkg.
- The hazard unit consumes Busy; the top level replaces the HI_Register/LO_Register pair with this block.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7, Start at cycle 0 -> Busy cycles 1..33; Done in cycle 34 with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Second Start issued in cycle 5 -> ignored; only one Done.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, DivByZero=0.
- DIVU 5/0 -> Done in cycle 34, LO=0xFFFFFFFF, HI=5, DivByZero=1 for that cycle only.
- MADD/MSUB sequence:
  - MTHI 0, MTLO 0xFFFFFFFF -> each takes effect the next cycle, Busy stays 0.
  - MADD 1*1 -> HI=1, LO=0.
  - After MTHI 0, MTLO 0: MSUB 1*1 -> HI=LO=0xFFFFFFFF.
- Abort cases:
  - DIVU started, Cancel in cycle 10 -> Busy low from cycle 11, HI/LO unchanged, no Done.
  - Reset asserted mid-MULT -> HI=LO=0, Busy=0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op codes carried on i_op
//   - FSM state encoding (also visible on the o_state debug port)
//   - clog2 helper that sizes the iteration counter
//   - cond_neg helper for sign conditioning (abs / negate)
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Widest value cond_neg handles. Callers size-cast the result back to their
  // own width; two's complement negation truncated to N bits is exactly
  // negation mod 2^N, so this stays correct for any 2*WIDTH <= MAX_W.
  localparam int MAX_W = 128;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Returns -v when neg is set, v otherwise.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                 input logic             neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit that owns the HI/LO registers.
//   MULT/MULTU/MADD/MSUB : radix-2 shift-add on magnitudes, WIDTH CALC cycles
//   DIV/DIVU             : restoring division on magnitudes, WIDTH CALC cycles
//   FIX                  : one cycle of sign correction / accumulate / commit
//   MTHI/MTLO            : written directly at the Start edge while IDLE
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_start        op request, honoured only in IDLE
//   i_op           op code (see muldiv_pkg)
//   i_operand_a    rs: multiplicand / dividend / MTHI-MTLO source
//   i_operand_b    rt: multiplier / divisor
//   i_cancel       flush; aborts an in-flight op, blocks a Start in IDLE
//   o_busy         high while the FSM is in CALC or FIX
//   o_done         one-cycle pulse; HI/LO already hold the result
//   o_div_by_zero  pulses with o_done for DIV/DIVU with a zero divisor
//   o_hi, o_lo     architectural HI/LO registers
//   o_state        current FSM state (debug visibility)
//
// Handshake: a request is taken on a rising edge where i_start=1, i_cancel=0
// and o_busy=0; anything offered while o_busy=1 is dropped, never queued.
// A taken iterative op produces exactly one o_done pulse WIDTH+2 cycles later
// unless it is cancelled or reset first.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit ENABLE_MADD = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_state
);

  localparam int CNT_W = clog2(WIDTH);
  localparam int W2    = 2 * WIDTH;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_b_mag;    // multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0] r_a_raw;    // raw dividend, reported in HI on divide by zero
  logic             r_neg;      // product / quotient needs negation
  logic             r_rem_neg;  // remainder takes the dividend's sign
  logic             r_div0;
  logic [WIDTH-1:0] r_p_hi;     // product high half / partial remainder
  logic [WIDTH-1:0] r_p_lo;     // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  // ---------------------------------------------------------------------------
  // Start decode and operand conditioning
  // ---------------------------------------------------------------------------
  logic             w_is_signed;
  logic             w_is_madd_op;
  logic             w_start_ok;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;

  assign w_is_signed  = (i_op == OP_MULT) || (i_op == OP_DIV) ||
                        (i_op == OP_MADD) || (i_op == OP_MSUB);
  assign w_is_madd_op = (i_op == OP_MADD) || (i_op == OP_MSUB);
  // Cancel beats Start in IDLE; with MADD disabled its ops look like a Cancel.
  assign w_start_ok   = i_start && !i_cancel && (r_state == ST_IDLE) &&
                        !(w_is_madd_op && !ENABLE_MADD);
  assign w_a_neg      = w_is_signed && i_operand_a[WIDTH-1];
  assign w_b_neg      = w_is_signed && i_operand_b[WIDTH-1];
  assign w_a_mag      = WIDTH'(cond_neg(MAX_W'(i_operand_a), w_a_neg));
  assign w_b_mag      = WIDTH'(cond_neg(MAX_W'(i_operand_b), w_b_neg));
  assign w_b_zero     = (i_operand_b == '0);

  // ---------------------------------------------------------------------------
  // One iteration of each datapath
  // ---------------------------------------------------------------------------
  logic             w_op_is_div;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  assign w_op_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);

  // Multiply: add the multiplicand when the current multiplier bit is set,
  // then shift the whole {hi,lo} pair right; product bits fill lo from the top.
  assign w_mul_sum = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_b_mag} : '0);

  // Divide: shift the next dividend bit into the partial remainder and keep
  // the subtraction when it does not borrow. The remainder is always below
  // the divisor, so WIDTH+1 bits hold the shifted value and bit WIDTH of the
  // trial difference is the borrow.
  assign w_div_shift = {r_p_hi, r_p_lo[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_b_mag};
  assign w_div_ge    = !w_div_trial[WIDTH];

  always_comb begin
    w_step_hi = r_p_hi;
    w_step_lo = r_p_lo;
    if (w_op_is_div) begin
      w_step_hi = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_step_lo = {r_p_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], r_p_lo[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // FIX-cycle result: sign correction, accumulate, divide-by-zero override
  // ---------------------------------------------------------------------------
  logic [W2-1:0]    w_prod;
  logic [W2-1:0]    w_acc;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_prod = W2'(cond_neg(MAX_W'({r_p_hi, r_p_lo}), r_neg));
  assign w_acc  = {r_hi, r_lo};
  assign w_quot = WIDTH'(cond_neg(MAX_W'(r_p_lo), r_neg));
  assign w_rem  = WIDTH'(cond_neg(MAX_W'(r_p_hi), r_rem_neg));

  // MIN / -1 needs no special case: |MIN| fits unsigned, both signs are
  // negative so the quotient MIN is not negated and the remainder is zero.
  always_comb begin
    w_fix_hi = w_prod[W2-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    case (r_op)
      OP_MADD: {w_fix_hi, w_fix_lo} = w_acc + w_prod;
      OP_MSUB: {w_fix_hi, w_fix_lo} = w_acc - w_prod;
      OP_DIV, OP_DIVU: begin
        if (r_div0) begin
          w_fix_hi = r_a_raw;
          w_fix_lo = '1;
        end else begin
          w_fix_hi = w_rem;
          w_fix_lo = w_quot;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM and register update
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= OP_MULT;
      r_b_mag   <= '0;
      r_a_raw   <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_div0    <= 1'b0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            if (i_op == OP_MTHI) begin
              r_hi <= i_operand_a;
            end else if (i_op == OP_MTLO) begin
              r_lo <= i_operand_a;
            end else begin
              r_state   <= ST_CALC;
              r_cnt     <= CNT_W'(WIDTH - 1);
              r_op      <= i_op;
              r_b_mag   <= w_b_mag;
              r_a_raw   <= i_operand_a;
              r_neg     <= w_a_neg ^ w_b_neg;
              r_rem_neg <= w_a_neg;
              r_div0    <= w_b_zero;
              r_p_hi    <= '0;
              r_p_lo    <= w_a_mag;
            end
          end
        end
        ST_CALC: begin
          if (i_cancel) begin
            r_state <= ST_IDLE;
          end else begin
            r_p_hi <= w_step_hi;
            r_p_lo <= w_step_lo;
            if (r_cnt == '0) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          if (!i_cancel) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
            r_dbz  <= w_op_is_div && r_div0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_state       = r_state;

endmodule
